i2c_slave_rx: RTL

- I2C target-side receiver: the responder to the team's I2C write initiator.
- Oversamples SCL/SDA with the system clock, detects START/STOP, and matches the 7-bit address.
- ACKs matching write transactions and delivers each received data byte on a valid/ready handshake.
- Sits at the board-side I2C pins (open-drain SDA) and feeds the register-file or command logic.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_line_sync.sv | 50 +++++
 rtl/i2c_slave_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Purpose : shared I2C definitions for the target receiver and the write initiator.
// Latency : n/a (types, constants and a pure helper function only).
// Backpr. : n/a.
package i2c_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2c_state_t;

    // R/W bit value in the address byte that selects a write transfer.
    localparam logic I2C_RW_WRITE = 1'b0;

    // SDA level during the ninth clock: low acknowledges, high refuses.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Bits per byte on the wire, excluding the acknowledge bit.
    localparam int I2C_BYTE_BITS = 8;

    // True when an address byte is a write aimed at own_addr.
    function automatic logic i2c_addr_hit(input logic [7:0] addr_byte,
                                          input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[0] == I2C_RW_WRITE);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Purpose : synchronises raw SCL/SDA and derives SCL edges plus START/STOP strobes.
// Latency : pin change reaches scl_s/sda_s after SYNC_STAGES clk; strobes are combinational from those.
// Backpr. : none; strobes are single-clk and must be consumed in the clk they appear.
//
// Ports: clk, rst_n (async active-low); scl_i/sda_i raw pins;
//        scl_s/sda_s synced levels; scl_rise/scl_fall edge strobes;
//        start_det (SDA falls while SCL high), stop_det_raw (SDA rises while SCL high).
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det_raw
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;

    // Chains preset to 1 (idle bus level) so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s        = scl_sync[SYNC_STAGES-1];
    assign sda_s        = sda_sync[SYNC_STAGES-1];
    assign scl_rise     =  scl_s & ~scl_prev;
    assign scl_fall     = ~scl_s &  scl_prev;
    assign start_det    =  scl_s &  sda_prev & ~sda_s;
    assign stop_det_raw =  scl_s & ~sda_prev &  sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// Purpose : I2C target receiver; matches a 7-bit write address, ACKs and emits data bytes.
// Latency : rx_valid pulses SYNC_STAGES+1 clk after the 8th SCL rising pin edge of a byte.
// Backpr. : rx_ready sampled at the 8th data bit; if low the byte is NACKed and dropped.
//
// Ports: clk, rst_n (async active-low); slave_addr own address;
//        scl_i/sda_i raw pins; sda_oe 1 = pull SDA low (open drain);
//        rx_data/rx_valid/rx_ready byte handshake; addr_match (address ACKed
//        until STOP/repeated START); busy (START..STOP); stop_det one-clk STOP pulse.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7   // 7-bit addressing only
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              addr_match,
    output logic              busy,
    output logic              stop_det
);

    logic       scl_s_unused;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det_raw;

    i2c_state_t state;
    logic [3:0] bit_cnt;
    logic [6:0] shift_q;     // first seven bits; the 8th comes straight from sda_s
    logic       ack_phase;   // 0 = waiting for the fall that starts the ACK slot
    logic [7:0] next_byte;
    logic       last_bit;

    // Only the edge strobes are needed here; the synced SCL level is unused.
    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .scl_s        (scl_s_unused),
        .sda_s        (sda_s),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .start_det    (start_det),
        .stop_det_raw (stop_det_raw)
    );

    assign next_byte = {shift_q, sda_s};
    assign last_bit  = (bit_cnt == 4'(I2C_BYTE_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shift_q    <= 7'd0;
            ack_phase  <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            stop_det <= 1'b0;

            // Bus conditions win over everything and release SDA in the same clk.
            if (stop_det_raw) begin
                state      <= ST_IDLE;
                bit_cnt    <= 4'd0;
                ack_phase  <= 1'b0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b0;
                stop_det   <= 1'b1;
            end else if (start_det) begin
                state      <= ST_ADDR;
                bit_cnt    <= 4'd0;
                ack_phase  <= 1'b0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= next_byte[6:0];
                            if (last_bit) begin
                                bit_cnt <= 4'd0;
                                state   <= i2c_addr_hit(next_byte, slave_addr)
                                           ? ST_ADDR_ACK : ST_IGNORE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // First fall after entry ends the 8th bit: pull SDA low for
                    // the ACK slot; the next fall ends the slot.
                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                ack_phase <= 1'b1;
                                sda_oe    <= 1'b1;
                                if (state == ST_ADDR_ACK) begin
                                    addr_match <= 1'b1;
                                end
                            end else begin
                                ack_phase <= 1'b0;
                                sda_oe    <= 1'b0;
                                bit_cnt   <= 4'd0;
                                state     <= ST_DATA;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (scl_rise) begin
                            shift_q <= next_byte[6:0];
                            if (last_bit) begin
                                bit_cnt <= 4'd0;
                                if (rx_ready) begin
                                    rx_data  <= next_byte;
                                    rx_valid <= 1'b1;
                                    state    <= ST_DATA_ACK;
                                end else begin
                                    // SDA stays released, so the master reads NACK.
                                    state <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        // ST_IDLE: wait for START.
                    end
                endcase
            end
        end
    end

endmodule
